exc_sched: RTL and testbench



---
 rtl/exc_sched.sv | 169 ++++++++++++++++
 tb/tb_exc_sched.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/exc_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exc_sched: exception/interrupt sequencer between MEM and CP0.              |
// | Captures one event, commits it to CP0, flushes, then drains.               |
// | Optional: EXC_INT_SYNC_EN adds a 2-flop synchronizer on int_i.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module exc_sched #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter logic [31:0] VEC_OFFSET   = 32'h180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] ebase_i,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_excepttype_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delay_slot_i,
    input  logic [31:0] mem_badvaddr_i,
    output logic        accept_o,
    output logic        busy_o,
    output logic [31:0] excepttype_o,
    output logic [31:0] exc_pc_o,
    output logic        exc_in_delay_slot_o,
    output logic [31:0] exc_badvaddr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_COMMIT = 2'd1;
    localparam logic [1:0] C_ST_FLUSH  = 2'd2;
    localparam logic [1:0] C_ST_DRAIN  = 2'd3;
    localparam logic [3:0] C_DRAIN_LOAD = 4'(DRAIN_CYCLES);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_code;
    logic [31:0] r_pc;
    logic        r_ds;
    logic [31:0] r_badvaddr;
    logic [31:0] r_target;

    logic [5:0]  w_int_src;
    logic [5:0]  w_int_eff;
    logic        w_int_pend;
    logic [31:0] w_legal_code;
    logic [31:0] w_code;
    logic [31:0] w_base;
    logic [31:0] w_target;
    logic        w_capture;
    logic        w_unused;

`ifdef EXC_INT_SYNC_EN
    logic [5:0] r_int_meta;
    logic [5:0] r_int_sync;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_int_meta <= 6'd0;
            r_int_sync <= 6'd0;
        end else begin
            r_int_meta <= int_i;
            r_int_sync <= r_int_meta;
        end
    end

    assign w_int_src = r_int_sync;
`else
    assign w_int_src = int_i;
`endif

    // Timer interrupt shares hardware line 5 and is already in the clk domain.
    assign w_int_eff  = {w_int_src[5] | timer_int_i, w_int_src[4:0]};
    assign w_int_pend = (|(w_int_eff & status_i[15:10])) & status_i[0] & ~status_i[1];

    always_comb begin
        case (mem_excepttype_i)
            32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'hf: w_legal_code = mem_excepttype_i;
            default:                                          w_legal_code = 32'ha;
        endcase
    end

    assign w_code    = w_int_pend ? 32'h1 : w_legal_code;
    assign w_capture = rst & (r_state == C_ST_IDLE) & mem_valid_i
                       & (w_int_pend | (mem_excepttype_i != 32'd0));

    // Target is resolved at capture so later CP0 updates cannot disturb it.
    assign w_base = {ebase_i[31:12], 12'h000};
    always_comb begin
        if (w_code == 32'he) begin
            w_target = epc_i;
        end else if ((w_code == 32'hf) && !status_i[1]) begin
            w_target = w_base;
        end else begin
            w_target = w_base + VEC_OFFSET;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            C_ST_IDLE: begin
                if (w_capture) begin
                    w_state_nxt = C_ST_COMMIT;
                end
            end
            C_ST_COMMIT: begin
                w_state_nxt = C_ST_FLUSH;
            end
            C_ST_FLUSH: begin
                w_state_nxt = C_ST_DRAIN;
                w_cnt_nxt   = C_DRAIN_LOAD;
            end
            C_ST_DRAIN: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = C_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= C_ST_IDLE;
            r_cnt      <= 4'd0;
            r_code     <= 32'd0;
            r_pc       <= 32'd0;
            r_ds       <= 1'b0;
            r_badvaddr <= 32'd0;
            r_target   <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_code     <= w_code;
                r_pc       <= mem_pc_i;
                r_ds       <= mem_in_delay_slot_i;
                r_badvaddr <= mem_badvaddr_i;
                r_target   <= w_target;
            end
        end
    end

    assign accept_o            = w_capture;
    assign busy_o              = (r_state != C_ST_IDLE);
    assign excepttype_o        = (r_state == C_ST_COMMIT) ? r_code     : 32'd0;
    assign exc_pc_o            = (r_state == C_ST_COMMIT) ? r_pc       : 32'd0;
    assign exc_in_delay_slot_o = (r_state == C_ST_COMMIT) ? r_ds       : 1'b0;
    assign exc_badvaddr_o      = (r_state == C_ST_COMMIT) ? r_badvaddr : 32'd0;
    assign flush_o             = (r_state == C_ST_FLUSH);
    assign new_pc_o            = (r_state == C_ST_FLUSH)  ? r_target   : 32'd0;

    assign w_unused = &{1'b0, cause_i, status_i[31:16], status_i[9:2]};

endmodule
`default_nettype wire

// File: tb/tb_exc_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_exc_sched: directed and randomized bench for exc_sched.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_exc_sched;

    localparam int unsigned C_D   = 2;
    localparam logic [31:0] C_VEC = 32'h180;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic [31:0] status_i, cause_i, epc_i, ebase_i;
    logic        mem_valid_i;
    logic [31:0] mem_excepttype_i, mem_pc_i, mem_badvaddr_i;
    logic        mem_in_delay_slot_i;
    logic        accept_o, busy_o, exc_in_delay_slot_o, flush_o;
    logic [31:0] excepttype_o, exc_pc_o, exc_badvaddr_o, new_pc_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time of last capture plus the values it committed.
    int          cyc   = 0;
    int          t_cap = -1000;
    logic [31:0] m_code, m_pc, m_bad, m_tgt;
    logic        m_ds;
    logic [5:0]  m_int_d1, m_int_d2;

    always #5 clk = ~clk;

    exc_sched #(.DRAIN_CYCLES(C_D), .VEC_OFFSET(C_VEC)) dut (
        .clk(clk), .rst(rst), .int_i(int_i), .timer_int_i(timer_int_i),
        .status_i(status_i), .cause_i(cause_i), .epc_i(epc_i), .ebase_i(ebase_i),
        .mem_valid_i(mem_valid_i), .mem_excepttype_i(mem_excepttype_i),
        .mem_pc_i(mem_pc_i), .mem_in_delay_slot_i(mem_in_delay_slot_i),
        .mem_badvaddr_i(mem_badvaddr_i), .accept_o(accept_o), .busy_o(busy_o),
        .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o),
        .exc_in_delay_slot_o(exc_in_delay_slot_o), .exc_badvaddr_o(exc_badvaddr_o),
        .flush_o(flush_o), .new_pc_o(new_pc_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] c);
        logic [31:0] legal [7] = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'hf};
        foreach (legal[k]) if (legal[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: check outputs against the model, then advance the model at the edge.
    task automatic tick();
        logic [5:0]  seen, ie;
        logic        pend, mbusy, macc;
        logic [31:0] code, base, tgt;
        int          dt;
        #1;
`ifdef EXC_INT_SYNC_EN
        seen = m_int_d2;
`else
        seen = int_i;
`endif
        ie    = {seen[5] | timer_int_i, seen[4:0]};
        pend  = ((ie & status_i[15:10]) != 6'd0) && status_i[0] && !status_i[1];
        dt    = cyc - t_cap;
        mbusy = (dt >= 1) && (dt <= 2 + int'(C_D));
        macc  = rst && !mbusy && mem_valid_i && (pend || mem_excepttype_i != 32'd0);
        code  = pend ? 32'h1 : (is_legal(mem_excepttype_i) ? mem_excepttype_i : 32'ha);
        base  = ebase_i & 32'hFFFF_F000;
        if (code == 32'he)                        tgt = epc_i;
        else if (code == 32'hf && !status_i[1])   tgt = base;
        else                                      tgt = base + C_VEC;

        chk("accept",     {31'd0, accept_o}, {31'd0, macc});
        chk("busy",       {31'd0, busy_o},   {31'd0, mbusy});
        chk("excepttype", excepttype_o,      (dt == 1) ? m_code : 32'd0);
        chk("exc_pc",     exc_pc_o,          (dt == 1) ? m_pc   : 32'd0);
        chk("exc_ds",     {31'd0, exc_in_delay_slot_o}, {31'd0, (dt == 1) && m_ds});
        chk("exc_bad",    exc_badvaddr_o,    (dt == 1) ? m_bad  : 32'd0);
        chk("flush",      {31'd0, flush_o},  {31'd0, dt == 2});
        chk("new_pc",     new_pc_o,          (dt == 2) ? m_tgt  : 32'd0);

        @(posedge clk);
        if (!rst) begin
            t_cap    = -1000;
            m_int_d1 = '0;
            m_int_d2 = '0;
        end else begin
            if (macc) begin
                t_cap  = cyc;
                m_code = code;
                m_pc   = mem_pc_i;
                m_ds   = mem_in_delay_slot_i;
                m_bad  = mem_badvaddr_i;
                m_tgt  = tgt;
            end
            m_int_d2 = m_int_d1;
            m_int_d1 = int_i;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        mem_valid_i = 1'b0; mem_excepttype_i = '0; int_i = '0; timer_int_i = 1'b0;
    endtask

    initial begin
        logic [31:0] pool [10] = '{32'h0, 32'h0, 32'h1, 32'h8, 32'ha, 32'hc,
                                   32'he, 32'hf, 32'h3, 32'h20};
        rst = 1'b0; idle_inputs();
        status_i = '0; cause_i = '0; epc_i = '0; ebase_i = 32'h8000_0000;
        mem_pc_i = '0; mem_in_delay_slot_i = 1'b0; mem_badvaddr_i = '0;
        m_code = '0; m_pc = '0; m_bad = '0; m_tgt = '0; m_ds = 1'b0;
        m_int_d1 = '0; m_int_d2 = '0;
        @(negedge clk);
        tick(); tick();
        #1 chk("reset_busy", {31'd0, busy_o}, 32'd0);

        // Syscall
        rst = 1'b1;
        mem_valid_i = 1'b1; mem_excepttype_i = 32'h8; mem_pc_i = 32'h8000_0100;
        mem_badvaddr_i = 32'hDEAD_0000;
        tick();
        idle_inputs();
        #1 chk("sys_code", excepttype_o, 32'h8);
        chk("sys_pc", exc_pc_o, 32'h8000_0100);
        tick();
        #1 chk("sys_newpc", new_pc_o, 32'h8000_0180);
        tick(); tick(); tick();
        #1 chk("sys_idle_T5", {31'd0, busy_o}, 32'd0);
        tick(); tick();

        // ERET
        mem_valid_i = 1'b1; mem_excepttype_i = 32'he; epc_i = 32'h8000_1234;
        tick(); idle_inputs(); tick();
        #1 chk("eret_newpc", new_pc_o, 32'h8000_1234);
        repeat (4) tick();

        // Interrupt beats simultaneous exception; EXL masks it
        status_i = 32'h0000_0401; int_i = 6'b000001;
        mem_valid_i = 1'b1; mem_excepttype_i = 32'hc;
        repeat (3) tick();
        idle_inputs();
        repeat (6) tick();
        status_i = 32'h0000_0403; int_i = 6'b000001;
        mem_valid_i = 1'b1; mem_excepttype_i = 32'hc;
        tick(); idle_inputs();
        #1 chk("exl_code", excepttype_o, 32'hc);
        repeat (5) tick();

        // Code f with EXL=0 then EXL=1
        status_i = 32'h0; mem_valid_i = 1'b1; mem_excepttype_i = 32'hf;
        mem_badvaddr_i = 32'h1234_5678;
        tick(); idle_inputs();
        #1 chk("f_bad", exc_badvaddr_o, 32'h1234_5678);
        tick();
        #1 chk("f_newpc_exl0", new_pc_o, 32'h8000_0000);
        repeat (4) tick();
        status_i = 32'h2; mem_valid_i = 1'b1; mem_excepttype_i = 32'hf;
        tick(); idle_inputs(); tick();
        #1 chk("f_newpc_exl1", new_pc_o, 32'h8000_0180);
        repeat (4) tick();

        // Back-to-back with valid held high
        status_i = 32'h0; mem_valid_i = 1'b1; mem_excepttype_i = 32'h8;
        repeat (16) tick();
        idle_inputs();
        repeat (5) tick();

        // Reset in the FLUSH cycle, released with a pending code
        mem_valid_i = 1'b1; mem_excepttype_i = 32'hd;
        tick(); tick();
        rst = 1'b0;
        tick();
        #1 chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_newpc", new_pc_o, 32'd0);
        rst = 1'b1;
        #1 chk("rst_release_accept", {31'd0, accept_o}, 32'd1);
        tick();
        idle_inputs();
        repeat (6) tick();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst                 = ($urandom_range(0, 60) != 0);
            mem_valid_i         = ($urandom_range(0, 2) != 0);
            mem_excepttype_i    = pool[$urandom_range(0, 9)];
            mem_pc_i            = $urandom;
            mem_badvaddr_i      = $urandom;
            mem_in_delay_slot_i = 1'($urandom);
            int_i               = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            timer_int_i         = ($urandom_range(0, 7) == 0);
            status_i            = $urandom & 32'h0000_FC03;
            epc_i               = $urandom;
            ebase_i             = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
